inst_encoder: RTL

Assembles RV32I instruction words from field-level requests, the inverse of the core's instruction decoder. Accepts one request per cycle over a valid/ready handshake, encodes it to a 32-bit word, and buffers words in a small FIFO feeding an instruction-injection port (boot sequencer, debug injector, or fetch-stage testbench driver). Optionally expands a load-immediate pseudo-op into a LUI+ADDI pair via a two-state FSM.

---
 rtl/inst_encoder_pkg.sv | 96 +++++++++
 rtl/inst_encoder_fifo.sv | 78 +++++++
 rtl/inst_encoder.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/inst_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder: request kinds,
// opcodes, funct constants, FSM state type and field-packing helpers.
package inst_encoder_pkg;

    // Request kinds presented on req_kind; codes 12..15 are illegal.
    localparam logic [3:0] KIND_R      = 4'd0;
    localparam logic [3:0] KIND_I_ALU  = 4'd1;
    localparam logic [3:0] KIND_LOAD   = 4'd2;
    localparam logic [3:0] KIND_STORE  = 4'd3;
    localparam logic [3:0] KIND_BRANCH = 4'd4;
    localparam logic [3:0] KIND_LUI    = 4'd5;
    localparam logic [3:0] KIND_AUIPC  = 4'd6;
    localparam logic [3:0] KIND_JAL    = 4'd7;
    localparam logic [3:0] KIND_JALR   = 4'd8;
    localparam logic [3:0] KIND_CSRRW  = 4'd9;
    localparam logic [3:0] KIND_CSRRWI = 4'd10;
    localparam logic [3:0] KIND_LI     = 4'd11;

    // Base RV32I major opcodes.
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADDI   = 3'b000;
    localparam logic [2:0] F3_SLLI   = 3'b001;
    localparam logic [2:0] F3_SRXI   = 3'b101;
    localparam logic [2:0] F3_JALR   = 3'b000;
    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRWI = 3'b101;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_LI_LO = 1'b1
    } enc_state_e;

    // True for kinds that encode to exactly one word without the FSM.
    function automatic logic is_single_kind(input logic [3:0] kind);
        return (kind <= KIND_CSRRWI);
    endfunction

    // ADDI rd, rs1, imm12
    function automatic logic [31:0] addi_word(input logic [4:0] rd, input logic [4:0] rs1,
                                              input logic [11:0] imm12);
        return {imm12, rs1, F3_ADDI, rd, OPC_OP_IMM};
    endfunction

    // LUI rd, hi20
    function automatic logic [31:0] lui_word(input logic [4:0] rd, input logic [19:0] hi20);
        return {hi20, rd, OPC_LUI};
    endfunction

    // Packs a single-word request into its RV32I format.
    function automatic logic [31:0] encode_word(input logic [3:0]  kind,
                                                input logic [2:0]  funct3,
                                                input logic        alt,
                                                input logic [4:0]  rd,
                                                input logic [4:0]  rs1,
                                                input logic [4:0]  rs2,
                                                input logic [31:0] imm);
        logic [31:0] word;
        logic [6:0]  f7;
        f7 = alt ? FUNCT7_ALT : FUNCT7_BASE;
        case (kind)
            KIND_R:      word = {f7, rs2, rs1, funct3, rd, OPC_OP};
            KIND_I_ALU: begin
                if ((funct3 == F3_SLLI) || (funct3 == F3_SRXI)) begin
                    word = {f7, imm[4:0], rs1, funct3, rd, OPC_OP_IMM};
                end else begin
                    word = {imm[11:0], rs1, funct3, rd, OPC_OP_IMM};
                end
            end
            KIND_LOAD:   word = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
            KIND_STORE:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
            KIND_BRANCH: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
            KIND_LUI:    word = {imm[31:12], rd, OPC_LUI};
            KIND_AUIPC:  word = {imm[31:12], rd, OPC_AUIPC};
            KIND_JAL:    word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
            KIND_JALR:   word = {imm[11:0], rs1, F3_JALR, rd, OPC_JALR};
            KIND_CSRRW:  word = {imm[11:0], rs1, F3_CSRRW, rd, OPC_SYSTEM};
            KIND_CSRRWI: word = {imm[11:0], rs1, F3_CSRRWI, rd, OPC_SYSTEM};
            default:     word = 32'd0;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/inst_encoder_fifo.sv
// Output word FIFO for the instruction encoder. Head word and count come
// straight from registers; push and pop may coincide at any fill level.
module inst_encoder_fifo
    import inst_encoder_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [31:0]   push_data,
    input  logic          pop,
    output logic [31:0]   head,
    output logic          head_valid,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_en_s;
    logic          pop_en_s;

    // Qualify push/pop against occupancy; a pop makes room for a push at full.
    always_comb begin
        pop_en_s  = pop && (count_r != CW'(0));
        push_en_s = push && ((count_r < DEPTH_C) || pop_en_s);
    end

    // Word storage, cleared so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'd0;
            end
        end else if (push_en_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
        end else begin
            if (push_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_en_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
        end
    end

    // Occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= CW'(0);
        end else begin
            case ({push_en_s, pop_en_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head       = mem_r[rd_ptr_r];
    assign head_valid = (count_r != CW'(0));
    assign count      = count_r;

endmodule

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: turns field-level requests into instruction
// words and queues them for an injection port.
// Build option: define INST_ENC_LI_EN to add the LI pseudo-op (LUI+ADDI
// expansion via the LI_LO state); otherwise LI is reported as illegal.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_kind,
    input  logic [2:0]  req_funct3,
    input  logic        req_alt,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [31:0] req_imm,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic        err_illegal
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    enc_state_e    state_r;
    enc_state_e    state_nxt_s;
    logic [CW-1:0] count_s;
    logic          fifo_free_s;
    logic          req_ready_s;
    logic          push_s;
    logic [31:0]   push_data_s;
    logic          illegal_s;
    logic          li_load_s;
    logic          err_illegal_r;

`ifdef INST_ENC_LI_EN
    logic [4:0]    li_rd_r;
    logic [11:0]   li_lo_r;
    logic [31:0]   li_sum_s;
    logic          li_small_s;

    // Range test and rounded upper half for the LI pseudo-op.
    always_comb begin
        li_sum_s   = req_imm + 32'h0000_0800;
        li_small_s = ($signed(req_imm) >= -32'sd2048) && ($signed(req_imm) <= 32'sd2047);
    end

    // Latch destination and low half while the LUI goes out first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            li_rd_r <= 5'd0;
            li_lo_r <= 12'd0;
        end else if (li_load_s) begin
            li_rd_r <= req_rd;
            li_lo_r <= req_imm[11:0];
        end
    end
`endif

    // req_ready depends only on registered state, never on inst_ready.
    always_comb begin
        fifo_free_s = (count_s < DEPTH_C);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (li_load_s) begin
                    state_nxt_s = ST_LI_LO;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
`ifdef INST_ENC_LI_EN
            ST_LI_LO: begin
                if (fifo_free_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_LI_LO;
                end
            end
`endif
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake, FIFO write and illegal-kind detection.
    always_comb begin
        req_ready_s = 1'b0;
        push_s      = 1'b0;
        push_data_s = 32'd0;
        illegal_s   = 1'b0;
        li_load_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                req_ready_s = fifo_free_s;
                if (req_valid && fifo_free_s) begin
                    if (is_single_kind(req_kind)) begin
                        push_s      = 1'b1;
                        push_data_s = encode_word(req_kind, req_funct3, req_alt, req_rd,
                                                  req_rs1, req_rs2, req_imm);
`ifdef INST_ENC_LI_EN
                    end else if (req_kind == KIND_LI) begin
                        push_s = 1'b1;
                        if (li_small_s) begin
                            push_data_s = addi_word(req_rd, 5'd0, req_imm[11:0]);
                        end else begin
                            push_data_s = lui_word(req_rd, li_sum_s[31:12]);
                            li_load_s   = 1'b1;
                        end
`endif
                    end else begin
                        illegal_s = 1'b1;
                    end
                end else begin
                    push_s = 1'b0;
                end
            end
`ifdef INST_ENC_LI_EN
            ST_LI_LO: begin
                if (fifo_free_s) begin
                    push_s      = 1'b1;
                    push_data_s = addi_word(li_rd_r, li_rd_r, li_lo_r);
                end else begin
                    push_s = 1'b0;
                end
            end
`endif
            default: begin
                req_ready_s = 1'b0;
            end
        endcase
    end

    // One-cycle error pulse after an illegal request is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_illegal_r <= 1'b0;
        end else begin
            err_illegal_r <= illegal_s;
        end
    end

    inst_encoder_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_s),
        .push_data  (push_data_s),
        .pop        (inst_ready),
        .head       (inst),
        .head_valid (inst_valid),
        .count      (count_s)
    );

    assign req_ready   = req_ready_s;
    assign err_illegal = err_illegal_r;

endmodule
